// File: rtl/branch_pkg.sv
// Shared encodings for branch resolution and BTB direction counters.
// Outcome and change-type codes share values so EX logic can pass them through.
package branch_pkg;

    // Resolved outcome reported to the pipeline
    localparam logic [1:0] OUT_SEQ       = 2'b00;
    localparam logic [1:0] OUT_BRANCH    = 2'b01;
    localparam logic [1:0] OUT_JUMP      = 2'b10;
    localparam logic [1:0] OUT_NOTBRANCH = 2'b11;

    // Instruction change type from decode; 2'b11 is unused
    localparam logic [1:0] CT_SEQ    = 2'b00;
    localparam logic [1:0] CT_BRANCH = 2'b01;
    localparam logic [1:0] CT_JUMP   = 2'b10;
    localparam logic [1:0] CT_UNUSED = 2'b11;

    // Two-bit direction counter states
    localparam logic [1:0] STRONG_NT = 2'd0;
    localparam logic [1:0] WEAK_NT   = 2'd1;
    localparam logic [1:0] WEAK_T    = 2'd2;
    localparam logic [1:0] STRONG_T  = 2'd3;

    function automatic logic [1:0] ctr_next(
        input logic [1:0] ctr,
        input logic       taken
    );
        logic [1:0] n;
        n = ctr;
        if (taken && ctr != STRONG_T) begin
            n = ctr + 2'd1;
        end else if (!taken && ctr != STRONG_NT) begin
            n = ctr - 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/branch_predict_unit_btb_array.sv
// Direct-mapped BTB storage: combinational IF read, clocked EX train/invalidate.
// Hit detection for the EX side lives here so the top only issues commands.
module btb_array
    import branch_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int PC_W    = 32,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = PC_W - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [PC_W-1:0]  rd_target_o,
    output logic [1:0]       rd_ctr_o,
    input  logic             wr_en_i,
    input  logic             inv_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [PC_W-1:0]  wr_target_i,
    input  logic             wr_taken_i,
    input  logic             wr_jump_i
);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [PC_W-1:0]    tgt_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];
    logic               wr_hit;

    assign rd_valid_o  = valid_q[rd_idx_i];
    assign rd_tag_o    = tag_q[rd_idx_i];
    assign rd_target_o = tgt_q[rd_idx_i];
    assign rd_ctr_o    = ctr_q[rd_idx_i];

    assign wr_hit = valid_q[wr_idx_i] && (tag_q[wr_idx_i] == wr_tag_i);

    // Train on hit, allocate on taken miss, drop stale entry on request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= WEAK_NT;
            end
        end else if (wr_en_i) begin
            if (wr_hit) begin
                ctr_q[wr_idx_i] <= ctr_next(ctr_q[wr_idx_i], wr_taken_i);
                tgt_q[wr_idx_i] <= wr_target_i;
            end else if (wr_taken_i) begin
                valid_q[wr_idx_i] <= 1'b1;
                tag_q[wr_idx_i]   <= wr_tag_i;
                tgt_q[wr_idx_i]   <= wr_target_i;
                ctr_q[wr_idx_i]   <= wr_jump_i ? STRONG_T : WEAK_T;
            end
        end else if (inv_en_i && wr_hit) begin
            valid_q[wr_idx_i] <= 1'b0;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch prediction and EX-stage resolution: BTB lookup in IF, training,
// misprediction redirect and saturating statistics in EX.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int PC_W    = 32,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   if_pc,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    input  logic              ex_valid,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic [1:0]        ex_change_type,
    input  logic              ex_reverse,
    input  logic              ex_zero,
    input  logic [PC_W-1:0]   ex_target,
    input  logic              ex_pred_taken,
    input  logic [PC_W-1:0]   ex_pred_target,
    output logic [1:0]        branch_or_jump,
    output logic              mispredict,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [STAT_W-1:0] branch_count,
    output logic [STAT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [PC_W-1:0]  rd_target;
    logic [1:0]       rd_ctr;
    logic             if_hit;
    logic             actual_taken;
    logic             is_branch;
    logic             is_jump;
    logic             train_en;
    logic             inv_en;
    logic             unused_if_bits;

    logic [STAT_W-1:0] br_cnt_q, br_cnt_d;
    logic [STAT_W-1:0] mp_cnt_q, mp_cnt_d;

    // Word-aligned PCs: bits [1:0] never select an entry
    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[PC_W-1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[PC_W-1:IDX_W+2];
    assign unused_if_bits = ^if_pc[1:0];

    btb_array #(
        .ENTRIES(ENTRIES),
        .PC_W   (PC_W)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (if_idx),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_target_o(rd_target),
        .rd_ctr_o   (rd_ctr),
        .wr_en_i    (train_en),
        .inv_en_i   (inv_en),
        .wr_idx_i   (ex_idx),
        .wr_tag_i   (ex_tag),
        .wr_target_i(ex_target),
        .wr_taken_i (actual_taken),
        .wr_jump_i  (is_jump)
    );

    assign if_hit      = rd_valid && (rd_tag == if_tag);
    assign pred_taken  = if_hit && rd_ctr[1];
    assign pred_target = pred_taken ? rd_target : '0;

    assign is_branch = ex_valid && (ex_change_type == CT_BRANCH);
    assign is_jump   = ex_valid && (ex_change_type == CT_JUMP);

    // Resolve the EX instruction; bubbles and unused codes act as Sequence
    always_comb begin
        branch_or_jump = OUT_SEQ;
        actual_taken   = 1'b0;
        if (is_branch) begin
            actual_taken   = ex_reverse ^ ex_zero;
            branch_or_jump = actual_taken ? OUT_BRANCH : OUT_NOTBRANCH;
        end else if (is_jump) begin
            actual_taken   = 1'b1;
            branch_or_jump = OUT_JUMP;
        end
    end

    assign mispredict = ex_valid &&
        ((ex_pred_taken != actual_taken) ||
         (actual_taken && (ex_pred_target != ex_target)));

    assign redirect_pc = actual_taken ? ex_target : ex_pc + PC_W'(4);

    assign train_en = is_branch || is_jump;
    assign inv_en   = ex_valid && !train_en && mispredict;

    // Next-state of the saturating statistics counters
    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (is_branch && br_cnt_q != '1) begin
            br_cnt_d = br_cnt_q + STAT_W'(1);
        end
        if (mispredict && mp_cnt_q != '1) begin
            mp_cnt_d = mp_cnt_q + STAT_W'(1);
        end
    end

    // Statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign branch_count     = br_cnt_q;
    assign mispredict_count = mp_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit (ENTRIES=16, STAT_W=4).
// Stimulus pushes hand-computed expectations; a negedge monitor checks them.
module tb_branch_predict_unit;

    localparam logic [1:0] SEQ = 2'b00;
    localparam logic [1:0] BR  = 2'b01;
    localparam logic [1:0] JMP = 2'b10;
    localparam logic [1:0] NB  = 2'b11;

    typedef struct {
        logic        pt;
        logic [31:0] ptgt;
        logic [1:0]  bj;
        logic        mis;
        logic [31:0] rpc;
        logic [3:0]  bc;
        logic [3:0]  mc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [1:0]  ex_change_type;
    logic        ex_reverse;
    logic        ex_zero;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic [1:0]  branch_or_jump;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [3:0]  branch_count;
    logic [3:0]  mispredict_count;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step  = 0;

    branch_predict_unit #(
        .ENTRIES(16),
        .PC_W   (32),
        .STAT_W (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .if_pc           (if_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .ex_valid        (ex_valid),
        .ex_pc           (ex_pc),
        .ex_change_type  (ex_change_type),
        .ex_reverse      (ex_reverse),
        .ex_zero         (ex_zero),
        .ex_target       (ex_target),
        .ex_pred_taken   (ex_pred_taken),
        .ex_pred_target  (ex_pred_target),
        .branch_or_jump  (branch_or_jump),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc),
        .branch_count    (branch_count),
        .mispredict_count(mispredict_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int s,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h want %0h", nm, s, act, exp);
        end
    endtask

    // Monitor: compare outputs against the oldest pending expectation
    initial begin
        exp_t e;
        int   s;
        s = 0;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pred_taken", s, 32'(pred_taken), 32'(e.pt));
                chk("pred_target", s, pred_target, e.ptgt);
                chk("branch_or_jump", s, 32'(branch_or_jump), 32'(e.bj));
                chk("mispredict", s, 32'(mispredict), 32'(e.mis));
                chk("redirect_pc", s, redirect_pc, e.rpc);
                chk("branch_count", s, 32'(branch_count), 32'(e.bc));
                chk("mispredict_count", s, 32'(mispredict_count), 32'(e.mc));
                s++;
            end
        end
    end

    task automatic ex(input logic v, input logic [1:0] ty,
                      input logic [31:0] pc, input logic rev,
                      input logic z, input logic [31:0] tgt,
                      input logic ept, input logic [31:0] eptg);
        ex_valid       = v;
        ex_change_type = ty;
        ex_pc          = pc;
        ex_reverse     = rev;
        ex_zero        = z;
        ex_target      = tgt;
        ex_pred_taken  = ept;
        ex_pred_target = eptg;
    endtask

    task automatic idle();
        ex(1'b0, SEQ, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic go(input logic [31:0] ifpc, input logic pt,
                      input logic [31:0] ptgt, input logic [1:0] bj,
                      input logic mis, input logic [31:0] rpc,
                      input int bc, input int mc);
        exp_t e;
        if_pc  = ifpc;
        e.pt   = pt;
        e.ptgt = ptgt;
        e.bj   = bj;
        e.mis  = mis;
        e.rpc  = rpc;
        e.bc   = 4'(bc);
        e.mc   = 4'(mc);
        q.push_back(e);
        step++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        if_pc = 32'h0;
        idle();
        @(posedge clk);
        #1;
        go(32'h40, 0, 32'h0, SEQ, 0, 32'h4, 0, 0);
        rst = 1'b0;

        // first taken branch: allocate, no same-cycle bypass
        ex(1, BR, 32'h40, 0, 1, 32'h80, 0, 32'h0);
        go(32'h40, 0, 32'h0, BR, 1, 32'h80, 0, 0);
        // not-taken twice: ctr 2->1->0
        ex(1, BR, 32'h40, 0, 0, 32'h80, 1, 32'h80);
        go(32'h40, 1, 32'h80, NB, 1, 32'h44, 1, 1);
        ex(1, BR, 32'h40, 0, 0, 32'h80, 0, 32'h0);
        go(32'h40, 0, 32'h0, NB, 0, 32'h44, 2, 2);
        // bubble with branch inputs: no effect
        ex(0, BR, 32'h40, 0, 1, 32'h80, 0, 32'h0);
        go(32'h40, 0, 32'h0, SEQ, 0, 32'h44, 3, 2);
        // taken from ctr 0 -> 1, still predicted not-taken
        ex(1, BR, 32'h40, 0, 1, 32'h80, 0, 32'h0);
        go(32'h40, 0, 32'h0, BR, 1, 32'h80, 3, 2);
        ex(0, BR, 32'h40, 0, 1, 32'h80, 0, 32'h0);
        go(32'h40, 0, 32'h0, SEQ, 0, 32'h44, 4, 3);

        // jump at 0x100 (aliases index 0): allocates strong-taken
        ex(1, JMP, 32'h100, 0, 0, 32'h200, 0, 32'h0);
        go(32'h100, 0, 32'h0, JMP, 1, 32'h200, 4, 3);
        // stale sequence prediction invalidates it
        ex(1, SEQ, 32'h100, 0, 0, 32'h0, 1, 32'h200);
        go(32'h100, 1, 32'h200, SEQ, 1, 32'h104, 4, 4);
        idle();
        go(32'h100, 0, 32'h0, SEQ, 0, 32'h4, 4, 5);

        // aliasing: 0x440 shares index with 0x40
        ex(1, BR, 32'h40, 0, 1, 32'h80, 0, 32'h0);
        go(32'h40, 0, 32'h0, BR, 1, 32'h80, 4, 5);
        idle();
        go(32'h440, 0, 32'h0, SEQ, 0, 32'h4, 5, 6);
        go(32'h40, 1, 32'h80, SEQ, 0, 32'h4, 5, 6);

        // five correctly predicted taken: ctr saturates at 3
        for (int k = 0; k < 5; k++) begin
            ex(1, BR, 32'h40, 0, 1, 32'h80, 1, 32'h80);
            go(32'h40, 1, 32'h80, BR, 0, 32'h80, 5 + k, 6);
        end
        ex(1, BR, 32'h40, 0, 0, 32'h80, 1, 32'h80);
        go(32'h40, 1, 32'h80, NB, 1, 32'h44, 10, 6);
        // unused type code behaves as sequence, no training
        ex(1, 2'b11, 32'h40, 0, 1, 32'h300, 0, 32'h0);
        go(32'h40, 1, 32'h80, SEQ, 0, 32'h44, 11, 7);

        // branch_count saturation at 15
        for (int k = 0; k < 6; k++) begin
            ex(1, BR, 32'h10, 0, 0, 32'h90, 0, 32'h0);
            go(32'h10, 0, 32'h0, NB, 0, 32'h14,
               (11 + k > 15) ? 15 : 11 + k, 7);
        end
        // reversed test: bne with zero=0 is taken
        ex(1, BR, 32'h10, 1, 0, 32'h90, 0, 32'h0);
        go(32'h10, 0, 32'h0, BR, 1, 32'h90, 15, 7);
        idle();
        go(32'h10, 1, 32'h90, SEQ, 0, 32'h4, 15, 8);
        go(32'h40, 1, 32'h80, SEQ, 0, 32'h4, 15, 8);

        // asynchronous reset mid-run
        rst = 1'b1;
        go(32'h40, 0, 32'h0, SEQ, 0, 32'h4, 0, 0);
        rst = 1'b0;
        go(32'h40, 0, 32'h0, SEQ, 0, 32'h4, 0, 0);
        go(32'h10, 0, 32'h0, SEQ, 0, 32'h4, 0, 0);

        @(negedge clk);
        #1;
        chk("drain", step, 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
